// File: rtl/stopwatch_timebase.sv
// Button conditioning, IDLE/RUNNING/PAUSED control and the seconds prescaler
// feeding the stopwatch BCD counter.
module stopwatch_timebase #(
    parameter int TICK_PERIOD = 10_000_000,
    parameter int PRESCALE_W  = 24,
    parameter int DB_CYCLES   = 16
) (
    input  logic clock,
    input  logic nRST,
    input  logic start_stop,
    input  logic clear_btn,
    output logic second_tick,
    output logic clear,
    output logic running,
    output logic paused
);
    // state    | meaning
    // S_IDLE   | stopped and zeroed, prescaler held at 0
    // S_RUN    | prescaler counting, second_tick issued on wrap
    // S_PAUSE  | prescaler frozen, partial second preserved
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0]       DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_PERIOD - 1);

    // bit 0 = start_stop, bit 1 = clear_btn
    logic [1:0]           btn_raw;
    logic [1:0]           meta_q, meta_d;
    logic [1:0]           sync_q, sync_d;
    logic [1:0][DB_W-1:0] cnt_q, cnt_d;
    logic [1:0]           db_q, db_d;
    logic [1:0]           db_dly_q, db_dly_d;
    logic [1:0]           press_evt;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic                  clear_q, clear_d;

    assign btn_raw = {clear_btn, start_stop};

    always_comb begin
        meta_d   = btn_raw;
        sync_d   = meta_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign press_evt = db_q & ~db_dly_q;

    // Clear beats start/stop; a start/stop event also suppresses the tick on that edge.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        if (press_evt[1]) begin
            state_d = S_IDLE;
            presc_d = '0;
            clear_d = 1'b1;
        end else if (press_evt[0]) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_RUN: begin
                    if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + PRESCALE_W'(1);
                    end
                end
                S_PAUSE: presc_d = presc_q;
                default: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge nRST) begin
        if (!nRST) begin
            meta_q   <= '0;
            sync_q   <= '0;
            cnt_q    <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            state_q  <= S_IDLE;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            clear_q  <= clear_d;
        end
    end

    assign second_tick = tick_q;
    assign clear       = clear_q;
    assign running     = (state_q == S_RUN);
    assign paused      = (state_q == S_PAUSE);

endmodule
